// File: rtl/pcie_dll_pkg.sv
// Shared PCIe data-link-layer definitions: DLLP CRC constants, the checker
// FSM state type, DLLP type codes and a small bit-order helper.
package pcie_dll_pkg;

  localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
  localparam logic [15:0] DLLP_CRC_SEED = 16'hFFFF;
  localparam int          DLLP_BYTES    = 6;

  // Receive FSM: how much of the current DLLP has been collected.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a start-of-DLLP beat
    HAVE1 = 2'd1,  // bytes 0-1 held
    HAVE2 = 2'd2   // bytes 0-3 held, next beat is the CRC
  } dllp_state_e;

  // DLLP type codes carried in byte 0.
  typedef enum logic [7:0] {
    DLLP_ACK          = 8'h00,
    DLLP_NAK          = 8'h10,
    DLLP_PM_ENTER_L1  = 8'h20,
    DLLP_PM_ENTER_L23 = 8'h21,
    DLLP_PM_AS_REQ_L1 = 8'h23,
    DLLP_PM_REQ_ACK   = 8'h24,
    DLLP_VENDOR       = 8'h30,
    DLLP_UPDATEFC_P   = 8'h80
  } dllp_type_e;

  // Reverse the bit order of one byte.
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

endpackage

// File: rtl/dllp_crc16_check_if.sv
// De-framed DLLP beat stream in, checked DLLP out with valid/ready.
// The checker takes the slave side; whoever feeds and drains it is master.
interface dllp_crc16_check_if;
  logic        rx_valid;
  logic        rx_sop;
  logic [15:0] rx_data;
  logic [31:0] dllp_data;
  logic        dllp_valid;
  logic        dllp_ready;

  modport master (
    output rx_valid, rx_sop, rx_data, dllp_ready,
    input  dllp_data, dllp_valid
  );

  modport slave (
    input  rx_valid, rx_sop, rx_data, dllp_ready,
    output dllp_data, dllp_valid
  );
endinterface

// File: rtl/dllp_crc16_step.sv
// One beat of the DLLP CRC-16: folds two bytes into the running CRC.
// The earlier byte sits in data[15:8]; each byte enters LSB first.
module dllp_crc16_step
  import pcie_dll_pkg::*;
(
  input  logic [15:0] data,
  input  logic [15:0] crc_in,
  output logic [15:0] crc_out
);

  // Serial LFSR unrolled over the 16 data bits of the beat.
  always_comb begin
    logic [15:0] c;
    logic        fb;
    // NOTE: every variable gets a value before any branch reads it, so no latch is inferred.
    c  = crc_in;
    fb = 1'b0;
    for (int b = 1; b >= 0; b--) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ data[8*b + i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ DLLP_CRC_POLY;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/dllp_crc16_check.sv
// Receive-side DLLP integrity checker. Collects the four content bytes of a
// DLLP from a 16-bit beat stream, re-computes the CRC-16, compares it with
// the two received CRC bytes and hands good DLLPs to a one-deep buffer.
module dllp_crc16_check
  import pcie_dll_pkg::*;
#(
  parameter int CNTWIDTH = 16,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  dllp_crc16_check_if.slave   bus,
  output logic                crc_err,
  output logic                frame_err,
  output logic                overflow,
  output logic [CNTWIDTH-1:0] good_count,
  output logic [CNTWIDTH-1:0] bad_count
);

  localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);

  dllp_state_e state;
  logic [15:0] crc;
  logic [15:0] crc_in;
  logic [15:0] crc_next;
  logic [15:0] crc_wire;
  logic [31:0] hold;
  logic        sop_beat;
  logic        cont_beat;
  logic        crc_ok;
  logic        verdict_good;
  logic        buf_free;

  assign sop_beat  = bus.rx_valid & bus.rx_sop;
  assign cont_beat = bus.rx_valid & ~bus.rx_sop;

  // A start-of-DLLP beat restarts from the seed whatever state we are in.
  assign crc_in = bus.rx_sop ? DLLP_CRC_SEED : crc;

  dllp_crc16_step u_step (
    .data    (bus.rx_data),
    .crc_in  (crc_in),
    .crc_out (crc_next)
  );

  // Finished CRC as it appears on the wire: complemented, each byte bit-reversed.
  assign crc_wire     = {bitrev8(~crc[15:8]), bitrev8(~crc[7:0])};
  assign crc_ok       = (crc_wire == bus.rx_data);
  assign verdict_good = crc_ok | ~CHECK_EN;
  assign buf_free     = ~bus.dllp_valid | bus.dllp_ready;

  // Capture content bytes as they arrive.
  // NOTE: this holding register has no reset; it is fully rewritten before it is ever copied out.
  always_ff @(posedge clk) begin
    if (sop_beat)
      hold[31:16] <= bus.rx_data;
    else if (cont_beat && state == HAVE1)
      hold[15:0] <= bus.rx_data;
  end

  // Beat-collection FSM with registered verdict pulses, output buffer and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      crc            <= DLLP_CRC_SEED;
      bus.dllp_data  <= '0;
      bus.dllp_valid <= 1'b0;
      crc_err        <= 1'b0;
      frame_err      <= 1'b0;
      overflow       <= 1'b0;
      good_count     <= '0;
      bad_count      <= '0;
    end else begin
      // NOTE: non-blocking throughout so every branch sees pre-edge values regardless of statement order.
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (bus.dllp_valid && bus.dllp_ready) bus.dllp_valid <= 1'b0;

      if (sop_beat) begin
        // A new DLLP start truncates whatever was being collected.
        if (state != IDLE) frame_err <= 1'b1;
        crc   <= crc_next;
        state <= HAVE1;
      end else if (cont_beat) begin
        unique case (state)
          IDLE: begin
            // Stray continuation beat outside a DLLP: ignored.
          end
          HAVE1: begin
            crc   <= crc_next;
            state <= HAVE2;
          end
          HAVE2: begin
            crc   <= DLLP_CRC_SEED;
            state <= IDLE;
            if (!verdict_good) begin
              crc_err <= 1'b1;
              if (bad_count != '1) bad_count <= bad_count + CNT_ONE;
            end else if (buf_free) begin
              bus.dllp_data  <= hold;
              bus.dllp_valid <= 1'b1;
              if (good_count != '1) good_count <= good_count + CNT_ONE;
            end else begin
              overflow <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dllp_crc16_check.sv
// Self-checking bench for dllp_crc16_check. Three instances: the main one
// (CRC enforced, 16-bit counters) checked through a scoreboard, one with the
// check disabled and one with 2-bit counters for saturation.
module tb_dllp_crc16_check;
  import pcie_dll_pkg::*;

  typedef enum logic [1:0] {EV_LOAD, EV_CRC, EV_FRAME, EV_OVF} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t         sb[$];
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        rdy = 1'b1;
  logic        held = 1'b0;
  logic [31:0] last_load = 32'h0;
  int          exp_good = 0;
  int          exp_bad = 0;

  dllp_type_e types [6] = '{DLLP_ACK, DLLP_NAK, DLLP_PM_ENTER_L1,
                            DLLP_PM_REQ_ACK, DLLP_VENDOR, DLLP_UPDATEFC_P};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dllp_crc16_check_if if0 ();
  dllp_crc16_check_if if1 ();
  dllp_crc16_check_if if2 ();

  logic        crc_err0, frame_err0, overflow0;
  logic [15:0] good0, bad0;
  logic        crc_err1, frame_err1, overflow1;
  logic [15:0] good1, bad1;
  logic        crc_err2, frame_err2, overflow2;
  logic [1:0]  good2, bad2;

  dllp_crc16_check #(.CNTWIDTH(16), .CHECK_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .bus(if0), .crc_err(crc_err0), .frame_err(frame_err0),
    .overflow(overflow0), .good_count(good0), .bad_count(bad0));

  dllp_crc16_check #(.CNTWIDTH(16), .CHECK_EN(1'b0)) u_nochk (
    .clk(clk), .reset(reset), .bus(if1), .crc_err(crc_err1), .frame_err(frame_err1),
    .overflow(overflow1), .good_count(good1), .bad_count(bad1));

  dllp_crc16_check #(.CNTWIDTH(2), .CHECK_EN(1'b1)) u_sat (
    .clk(clk), .reset(reset), .bus(if2), .crc_err(crc_err2), .frame_err(frame_err2),
    .overflow(overflow2), .good_count(good2), .bad_count(bad2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference CRC: bit-serial over the 32 content bits, then complement and
  // place on the wire with each CRC byte bit-reversed.
  function automatic logic [15:0] golden_crc(input logic [31:0] content);
    logic [15:0] r;
    logic [15:0] w;
    logic        bitv;
    r = 16'hFFFF;
    for (int k = 0; k < 32; k++) begin
      bitv = content[24 - 8*(k/8) + (k%8)];
      if (r[15] ^ bitv) r = (r << 1) ^ 16'h100B;
      else              r = r << 1;
    end
    r = ~r;
    for (int i = 0; i < 8; i++) begin
      w[8 + i] = r[15 - i];
      w[i]     = r[7 - i];
    end
    return w;
  endfunction

  // Drive one beat just after a rising edge; only instance sel sees rx_valid.
  task automatic beat(input int sel, input logic v, input logic s, input logic [15:0] d);
    @(posedge clk);
    #1;
    if0.rx_valid = v & (sel == 0);
    if1.rx_valid = v & (sel == 1);
    if2.rx_valid = v & (sel == 2);
    if0.rx_sop = s;  if1.rx_sop = s;  if2.rx_sop = s;
    if0.rx_data = d; if1.rx_data = d; if2.rx_data = d;
    if0.dllp_ready = rdy;
  endtask

  task automatic idle(input int sel);
    beat(sel, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
  endtask

  // Expected outcome of a completed DLLP on the main instance.
  task automatic push_verdict(input logic [31:0] content, input logic good);
    int ec;
    ec = cyc + 1;
    if (!good) begin
      sb.push_back('{kind: EV_CRC, data: 32'h0, cyc: ec});
      exp_bad++;
    end else if (held && !rdy) begin
      sb.push_back('{kind: EV_OVF, data: 32'h0, cyc: ec});
    end else begin
      sb.push_back('{kind: EV_LOAD, data: content, cyc: ec});
      exp_good++;
      held = ~rdy;
    end
  endtask

  task automatic send(input int sel, input logic [31:0] content, input logic [15:0] flip,
                      input int gap, input logic set_rdy);
    beat(sel, 1'b1, 1'b1, content[31:16]);
    repeat (gap) idle(sel);
    beat(sel, 1'b1, 1'b0, content[15:0]);
    repeat (gap) idle(sel);
    if (set_rdy) rdy = 1'b1;
    beat(sel, 1'b1, 1'b0, golden_crc(content) ^ flip);
    if (sel == 0) push_verdict(content, flip == 16'h0);
    idle(sel);
  endtask

  // First DLLP cut short after a_beats beats by the start of b.
  task automatic send_trunc(input logic [31:0] a, input int a_beats, input logic [31:0] b);
    beat(0, 1'b1, 1'b1, a[31:16]);
    if (a_beats == 2) beat(0, 1'b1, 1'b0, a[15:0]);
    beat(0, 1'b1, 1'b1, b[31:16]);
    sb.push_back('{kind: EV_FRAME, data: 32'h0, cyc: cyc + 1});
    beat(0, 1'b1, 1'b0, b[15:0]);
    beat(0, 1'b1, 1'b0, golden_crc(b));
    push_verdict(b, 1'b1);
    idle(0);
  endtask

  task automatic take(input ev_kind_e kind, input logic [31:0] data);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_cycle", cyc, e.cyc);
      if (kind == EV_LOAD) begin
        check("load_data", data, e.data);
        last_load = e.data;
      end
    end
  endtask

  // Monitor for the main instance, sampling on the falling edge.
  initial begin : monitor
    logic prev_vld;
    logic prev_rdy;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_vld = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (prev_vld && !prev_rdy) begin
          check("hold_valid", 32'(if0.dllp_valid), 32'd1);
          check("hold_data", if0.dllp_data, last_load);
        end else if (if0.dllp_valid) begin
          take(EV_LOAD, if0.dllp_data);
        end
        if (crc_err0)   take(EV_CRC, 32'h0);
        if (frame_err0) take(EV_FRAME, 32'h0);
        if (overflow0)  take(EV_OVF, 32'h0);
        prev_vld = if0.dllp_valid;
        prev_rdy = if0.dllp_ready;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] ack5;
    logic [31:0] content;
    logic [15:0] flip;
    int          sh;
    int          sat_exp;
    ack5 = {DLLP_ACK, 12'h000, 12'h005};

    if0.rx_valid = 1'b0; if1.rx_valid = 1'b0; if2.rx_valid = 1'b0;
    if0.rx_sop = 1'b0;   if1.rx_sop = 1'b0;   if2.rx_sop = 1'b0;
    if0.rx_data = 16'h0; if1.rx_data = 16'h0; if2.rx_data = 16'h0;
    if0.dllp_ready = 1'b1; if1.dllp_ready = 1'b1; if2.dllp_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(if0.dllp_valid), 32'd0);
    check("rst_data", if0.dllp_data, 32'h0);
    check("rst_pulses", {29'd0, crc_err0, frame_err0, overflow0}, 32'd0);
    check("rst_good", 32'(good0), 32'd0);
    check("rst_bad", 32'(bad0), 32'd0);
    reset = 1'b0;

    // Good Ack, back-to-back beats.
    send(0, ack5, 16'h0, 0, 1'b0);
    check("ack_good_count", 32'(good0), 32'(exp_good));
    check("ack_crc_err", 32'(crc_err0), 32'd0);

    // Same Ack with CRC bit 0 flipped: dropped and counted.
    send(0, ack5, 16'h0001, 0, 1'b0);
    check("bad_crc_pulse", 32'(crc_err0), 32'd1);
    check("bad_valid", 32'(if0.dllp_valid), 32'd0);
    check("bad_count", 32'(bad0), 32'(exp_bad));

    // With the check disabled the corrupt DLLP is accepted.
    send(1, ack5, 16'h0001, 0, 1'b0);
    check("nochk_valid", 32'(if1.dllp_valid), 32'd1);
    check("nochk_data", if1.dllp_data, ack5);
    check("nochk_good", 32'(good1), 32'd1);
    check("nochk_crc_err", 32'(crc_err1), 32'd0);

    // Three idle cycles between beats.
    send(0, {DLLP_NAK, 12'h000, 12'hABC}, 16'h0, 3, 1'b0);
    check("gap_good_count", 32'(good0), 32'(exp_good));

    // Early RxSop in HAVE1 and in HAVE2.
    send_trunc(32'h2000_1111, 1, {DLLP_ACK, 12'h000, 12'h123});
    send_trunc(32'h2400_2222, 2, {DLLP_VENDOR, 24'h5A_A55A});
    check("trunc_bad_count", 32'(bad0), 32'(exp_bad));
    check("trunc_good_count", 32'(good0), 32'(exp_good));

    // Downstream stalled: first DLLP held, second overflows, third loads on drain.
    rdy = 1'b0;
    send(0, 32'h8001_0203, 16'h0, 0, 1'b0);
    send(0, 32'h8004_0506, 16'h0, 1, 1'b0);
    check("stall_held_data", if0.dllp_data, 32'h8001_0203);
    check("stall_ovf_pulse", 32'(overflow0), 32'd1);
    check("stall_good_count", 32'(good0), 32'(exp_good));
    send(0, 32'h8007_0809, 16'h0, 0, 1'b1);
    check("drain_ovf", 32'(overflow0), 32'd0);
    check("drain_data", if0.dllp_data, 32'h8007_0809);

    // Random mix of DLLP types, corruptions and gaps.
    for (int n = 0; n < 10; n++) begin
      content = {types[$urandom_range(0, 5)], 24'($urandom)};
      flip = 16'h0;
      if ($urandom_range(0, 2) == 0) begin
        sh = $urandom_range(0, 15);
        flip[sh] = 1'b1;
      end
      send(0, content, flip, $urandom_range(0, 2), 1'b0);
    end
    check("rand_good_count", 32'(good0), 32'(exp_good));
    check("rand_bad_count", 32'(bad0), 32'(exp_bad));

    // 2-bit counter saturation.
    for (int i = 1; i <= 5; i++) begin
      send(2, ack5, 16'h8000, 0, 1'b0);
      sat_exp = (i < 3) ? i : 3;
      check("sat_crc_pulse", 32'(crc_err2), 32'd1);
      check("sat_bad_count", 32'(bad2), 32'(sat_exp));
    end

    // Reset while holding bytes 0-3 of a DLLP.
    beat(0, 1'b1, 1'b1, 16'h1000);
    beat(0, 1'b1, 1'b0, 16'h0042);
    idle(0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(if0.dllp_valid), 32'd0);
    check("mid_rst_data", if0.dllp_data, 32'h0);
    check("mid_rst_pulses", {29'd0, crc_err0, frame_err0, overflow0}, 32'd0);
    check("mid_rst_counts", {good0, bad0}, 32'd0);
    check("mid_rst_sat", 32'(bad2), 32'd0);
    reset = 1'b0;
    exp_good = 0;
    exp_bad = 0;
    held = 1'b0;
    // The stale CRC beat now lands in IDLE and must be discarded.
    beat(0, 1'b1, 1'b0, golden_crc(32'h1000_0042));
    idle(0);
    send(0, 32'h1000_0042, 16'h0, 0, 1'b0);
    check("post_rst_good", 32'(good0), 32'd1);
    check("post_rst_bad", 32'(bad0), 32'd0);

    repeat (4) idle(0);
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
